toggle_event_receiver: RTL
==========================

Name: toggle_event_receiver

Overview:
- Destination-domain (clk_b) stage placed directly downstream of the two-flop level synchronizer.
- Consumes the synchronized toggle-encoded level. Each transition, rising or falling, is one event.
- Converts transitions into counted events and presents them on a valid/ready handshake to clk_b logic.
- Honours the same level_en low-power gating as the synchronizer.

Parameters:
- CNT_W, 4, width of pending-event counter; saturates at 2^CNT_W-1.
- TIMEOUT_CYC, 255, stall cycles before timeout_err; used only when TIMEOUT_EN is defined.
- TO_W, 8, timeout counter width; TIMEOUT_CYC must fit in it.

Ports:
- clk_b  in  1  destination clock; the only clock.
- rst_n_b  in  1  synchronous, active-low reset.
- level_en  in  1  block enable; 0 = sleep.
- sync_lvl  in  1  synchronized toggle level (synchronizer vld_out).
- evt_ready  in  1  downstream accepts one event.
- err_clr  in  1  clears sticky error flags.
- evt_valid  out  1  at least one event pending.
- evt_count  out  CNT_W  pending-event count.
- ovf  out  1  sticky: an event was lost to saturation.
- busy  out  1  evt_count != 0, regardless of state.
- timeout_err  out  1  sticky stall error; tied 0 without TIMEOUT_EN.

Behaviour:
- Reset (rst_n_b=0 at posedge clk_b):
  - state=WAKE, lvl_q=0, evt_count=0, ovf=0, timeout_err=0, timeout counter=0.
  - evt_valid=0, busy=0.
- States:
  - ACTIVE: if level_en=0, go to SLEEP.
  - SLEEP: if level_en=1, go to WAKE.
  - WAKE: if level_en=1, go to ACTIVE; else go to SLEEP.
- Edge detection (ACTIVE only):
  - edge = sync_lvl ^ lvl_q; lvl_q <= sync_lvl every ACTIVE cycle.
  - A transition seen at cycle n raises evt_count at posedge n+1, so evt_valid is high from cycle n+1.
- WAKE:
  - lvl_q <= sync_lvl (resample); no event is generated.
  - Transitions during SLEEP/WAKE are discarded by design; upstream must not toggle while disabled.
- SLEEP:
  - lvl_q, evt_count and flags hold.
  - Edge detection is off.
- evt_valid = (state==ACTIVE) && (evt_count!=0). It is forced 0 in SLEEP/WAKE, even when the count is nonzero.
- Accept = evt_valid & evt_ready. Each accept decrements evt_count by one event.
- Counter update per cycle:
  - edge and accept together: count unchanged.
  - edge only: count+1.
  - accept only: count-1.
  - Underflow is impossible because accept requires count!=0.
- Saturation: edge without accept at count=2^CNT_W-1 leaves count unchanged and sets ovf=1. Edge plus accept at max is net 0, so no overflow.
- err_clr=1 clears ovf and timeout_err next cycle. A set condition in the same cycle wins and the flag stays 1.
- All outputs are registered or decoded only from registered state. No combinational path from evt_ready to evt_valid.
- Mid-operation reset returns everything to reset values within one clock. Pending events are dropped.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter increments each cycle with evt_valid=1 and evt_ready=0.
  - It clears on accept, on leaving ACTIVE, and on reset.
  - When it reaches TIMEOUT_CYC, timeout_err sets the next cycle.
  - The counter then holds at TIMEOUT_CYC until cleared.
- Not defined: no counter logic; timeout_err constant 0.

Test Plan:
- Reset release with sync_lvl=1 -> WAKE samples 1, no event; evt_count=0, evt_valid=0 after 2 cycles.
- In ACTIVE, toggle sync_lvl 0->1->0 on cycles 10 and 14 with evt_ready=0:
  - evt_count=1 at cycle 11, =2 at cycle 15.
  - Raise evt_ready at cycle 20: count 1 at cycle 21, 0 at cycle 22, evt_valid low at cycle 22.
- Toggle each cycle with evt_ready=1 held -> evt_count steady at 1; evt_valid stays 1 while toggling.
- CNT_W=4, 16 toggles with evt_ready=0 -> count saturates at 15, ovf=1.
  - err_clr pulse -> ovf=0; evt_count stays 15.
- level_en=0 with count=3, toggle sync_lvl twice, then level_en=1:
  - evt_valid=0 during SLEEP.
  - Count remains 3 after WAKE; evt_valid=1 in ACTIVE.
- TIMEOUT_EN, TIMEOUT_CYC=8, one pending event with evt_ready=0 -> timeout_err=1 after 9 stall cycles; err_clr clears it.

Source files
------------

// File: rtl/toggle_event_receiver.sv
// ---------------------------------------------------------------------------
// toggle_event_receiver
//
// Purpose:
//   The clk_b-domain stage that sits right after the two-flop level
//   synchronizer. Every transition of the synchronized toggle level, rising
//   or falling, is one event. Events are counted and presented to clk_b logic
//   on a valid/ready handshake. The block follows the same level_en
//   low-power gating as the synchronizer.
//
// Optional feature:
//   TIMEOUT_EN - when defined, a stall counter raises the sticky timeout_err
//                flag after TIMEOUT_CYC cycles of evt_valid=1 / evt_ready=0.
//                When undefined, timeout_err is tied to 0.
//
// Ports:
//   clk_b        in   1      destination clock (only clock)
//   rst_n_b      in   1      synchronous active-low reset
//   level_en     in   1      block enable, 0 = sleep
//   sync_lvl     in   1      synchronized toggle level
//   evt_ready    in   1      downstream accepts one event
//   err_clr      in   1      clears the sticky error flags
//   evt_valid    out  1      at least one event pending (ACTIVE only)
//   evt_count    out  CNT_W  pending-event count, saturating
//   ovf          out  1      sticky: an event was lost to saturation
//   busy         out  1      evt_count != 0, regardless of state
//   timeout_err  out  1      sticky stall error
// ---------------------------------------------------------------------------
module toggle_event_receiver #(
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk_b,
    input  logic             rst_n_b,
    input  logic             level_en,
    input  logic             sync_lvl,
    input  logic             evt_ready,
    input  logic             err_clr,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_count,
    output logic             ovf,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_WAKE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SLEEP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // The stall limit has to be representable in the stall counter.
    if (TIMEOUT_CYC < 0 || TIMEOUT_CYC >= (2 ** TO_W)) begin : g_to_cyc_range
        $error("TIMEOUT_CYC does not fit in TO_W bits");
    end

    state_t           state_r;
    state_t           next_state_s;
    logic             lvl_q_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             ovf_r;
    logic             ovf_set_s;
    logic             active_s;
    logic             edge_s;
    logic             valid_s;
    logic             accept_s;

    // Decode of registered state only; evt_ready never reaches evt_valid.
    always_comb begin
        active_s = (state_r == ST_ACTIVE);
        edge_s   = active_s & (sync_lvl ^ lvl_q_r);
        valid_s  = active_s & (count_r != CNT_ZERO);
        accept_s = valid_s & evt_ready;
    end

    // Next-state logic for the enable/sleep sequencing.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_ACTIVE: begin
                if (!level_en) begin
                    next_state_s = ST_SLEEP;
                end else begin
                    next_state_s = ST_ACTIVE;
                end
            end
            ST_SLEEP: begin
                if (level_en) begin
                    next_state_s = ST_WAKE;
                end else begin
                    next_state_s = ST_SLEEP;
                end
            end
            ST_WAKE: begin
                if (level_en) begin
                    next_state_s = ST_ACTIVE;
                end else begin
                    next_state_s = ST_SLEEP;
                end
            end
            default: begin
                // Unknown encoding: recover through WAKE so lvl_q is resampled.
                next_state_s = ST_WAKE;
            end
        endcase
    end

    // Pending-count arithmetic: edge and accept cancel, saturation sets ovf.
    always_comb begin
        count_nxt_s = count_r;
        ovf_set_s   = 1'b0;
        if (edge_s && !accept_s) begin
            if (count_r == CNT_MAX) begin
                ovf_set_s = 1'b1;
            end else begin
                count_nxt_s = count_r + CNT_ONE;
            end
        end else if (accept_s && !edge_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State, sampled level, pending count and overflow flag registers.
    always_ff @(posedge clk_b) begin
        if (!rst_n_b) begin
            state_r <= ST_WAKE;
            lvl_q_r <= 1'b0;
            count_r <= CNT_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            // WAKE resamples without generating an event; SLEEP holds.
            if (state_r != ST_SLEEP) begin
                lvl_q_r <= sync_lvl;
            end
            count_r <= count_nxt_s;
            // A set in the same cycle as err_clr wins.
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (err_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

`ifdef TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_ZERO  = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_r;
    logic            to_err_r;

    // Stall counter: counts refused cycles, holds at the limit, clears on
    // accept or when ACTIVE is being left.
    always_ff @(posedge clk_b) begin
        if (!rst_n_b) begin
            to_cnt_r <= TO_ZERO;
        end else if (accept_s || (next_state_s != ST_ACTIVE)) begin
            to_cnt_r <= TO_ZERO;
        end else if (valid_s && !evt_ready && (to_cnt_r != TO_LIMIT)) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end
    end

    // Sticky timeout flag, set one cycle after the counter reaches the limit.
    always_ff @(posedge clk_b) begin
        if (!rst_n_b) begin
            to_err_r <= 1'b0;
        end else if (to_cnt_r == TO_LIMIT) begin
            to_err_r <= 1'b1;
        end else if (err_clr) begin
            to_err_r <= 1'b0;
        end
    end

    assign timeout_err = to_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    assign evt_valid = valid_s;
    assign evt_count = count_r;
    assign ovf       = ovf_r;
    assign busy      = (count_r != CNT_ZERO);

endmodule
